// File: rtl/hazard_forward_scoreboard.sv
// Hazard, forwarding and multi-cycle MD scoreboard for the 5-stage CPU.
// Sits beside the control unit between ID and EX.
//
// Ports:
//   clk, rst                      clock, async active-high reset
//   id_valid, id_rs, id_rt,
//   id_rs_used, id_rt_used,
//   id_is_md                      ID-stage instruction info
//   ex_RegWrite, ex_MemRead,
//   ex_RegisterRd                 EX-stage producer info (load-use)
//   exe_Rs, exe_Rt                EX-stage source indices (forwarding)
//   mem_/wb_RegWrite, _RegisterRd MEM/WB producers
//   md_start, md_rd               MD issue from EX
//   ForwardA, ForwardB            00 regfile, 01 WB, 10 MEM, 11 MD
//   stall_if_id, bubble_id_ex     hold IF/ID, inject NOP into ID/EX
//   md_busy, md_wb_valid, md_wb_rd  scoreboard status (registered)
// Optional: define HAZARD_PERF_CNT_EN to add perf_lu_stalls,
//   perf_md_stalls and perf_fwd_events (32-bit saturating counters).
module hazard_forward_scoreboard #(
    parameter int REG_ADDR_W = 5,
    parameter int MD_LATENCY = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_rs_used,
    input  logic                  id_rt_used,
    input  logic                  id_is_md,
    input  logic                  ex_RegWrite,
    input  logic                  ex_MemRead,
    input  logic [REG_ADDR_W-1:0] ex_RegisterRd,
    input  logic [REG_ADDR_W-1:0] exe_Rs,
    input  logic [REG_ADDR_W-1:0] exe_Rt,
    input  logic                  mem_RegWrite,
    input  logic                  wb_RegWrite,
    input  logic [REG_ADDR_W-1:0] mem_RegisterRd,
    input  logic [REG_ADDR_W-1:0] wb_RegisterRd,
    input  logic                  md_start,
    input  logic [REG_ADDR_W-1:0] md_rd,
    output logic [1:0]            ForwardA,
    output logic [1:0]            ForwardB,
    output logic                  stall_if_id,
    output logic                  bubble_id_ex,
    output logic                  md_busy,
    output logic                  md_wb_valid,
    output logic [REG_ADDR_W-1:0] md_wb_rd
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]           perf_lu_stalls,
    output logic [31:0]           perf_md_stalls,
    output logic [31:0]           perf_fwd_events
`endif
);

    localparam logic [REG_ADDR_W-1:0] ZERO = '0;
    localparam logic [3:0] LOAD = 4'(MD_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } md_state_t;

    md_state_t  state;
    logic [3:0] cnt;

    // Scoreboard FSM; md_busy/md_wb_valid are registered copies of the
    // next state so they line up exactly with BUSY/DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            md_wb_rd    <= ZERO;
            md_busy     <= 1'b0;
            md_wb_valid <= 1'b0;
        end else begin
            md_busy     <= 1'b0;
            md_wb_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (md_start) begin
                        state    <= BUSY;
                        cnt      <= LOAD;
                        md_wb_rd <= md_rd;
                        md_busy  <= 1'b1;
                    end
                end
                BUSY: begin
                    // md_start here is ignored; the MD hazard stalls it
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state       <= DONE;
                        md_wb_valid <= 1'b1;
                    end else begin
                        md_busy <= 1'b1;
                    end
                end
                DONE: begin
                    // back-to-back issue reloads without an IDLE gap
                    if (md_start) begin
                        state    <= BUSY;
                        cnt      <= LOAD;
                        md_wb_rd <= md_rd;
                        md_busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic md_a, md_b, mem_a, mem_b, wb_a, wb_b;

    always_comb begin
        md_a  = md_wb_valid && (md_wb_rd != ZERO) && (md_wb_rd == exe_Rs);
        md_b  = md_wb_valid && (md_wb_rd != ZERO) && (md_wb_rd == exe_Rt);
        mem_a = mem_RegWrite && (mem_RegisterRd != ZERO)
                && (mem_RegisterRd == exe_Rs);
        mem_b = mem_RegWrite && (mem_RegisterRd != ZERO)
                && (mem_RegisterRd == exe_Rt);
        wb_a  = wb_RegWrite && (wb_RegisterRd != ZERO)
                && (wb_RegisterRd == exe_Rs);
        wb_b  = wb_RegWrite && (wb_RegisterRd != ZERO)
                && (wb_RegisterRd == exe_Rt);
    end

    always_comb begin
        ForwardA = 2'b00;
        if (!rst) begin
            if (md_a)       ForwardA = 2'b11;
            else if (mem_a) ForwardA = 2'b10;
            else if (wb_a)  ForwardA = 2'b01;
        end
    end

    always_comb begin
        ForwardB = 2'b00;
        if (!rst) begin
            if (md_b)       ForwardB = 2'b11;
            else if (mem_b) ForwardB = 2'b10;
            else if (wb_b)  ForwardB = 2'b01;
        end
    end

    logic lu_hazard, md_dep, md_hazard, hazard;

    always_comb begin
        lu_hazard = id_valid && ex_MemRead && ex_RegWrite
                    && (ex_RegisterRd != ZERO)
                    && ((id_rs_used && (id_rs == ex_RegisterRd))
                     || (id_rt_used && (id_rt == ex_RegisterRd)));
        md_dep    = (md_wb_rd != ZERO)
                    && ((id_rs_used && (id_rs == md_wb_rd))
                     || (id_rt_used && (id_rt == md_wb_rd)));
        md_hazard = id_valid && md_busy && (id_is_md || md_dep);
        hazard    = !rst && (lu_hazard || md_hazard);
    end

    assign stall_if_id  = hazard;
    assign bubble_id_ex = hazard;

`ifdef HAZARD_PERF_CNT_EN
    logic fwd_event;
    assign fwd_event = (ForwardA != 2'b00) || (ForwardB != 2'b00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_lu_stalls  <= 32'd0;
            perf_md_stalls  <= 32'd0;
            perf_fwd_events <= 32'd0;
        end else begin
            if (lu_hazard && !(&perf_lu_stalls))
                perf_lu_stalls <= perf_lu_stalls + 32'd1;
            if (md_hazard && !(&perf_md_stalls))
                perf_md_stalls <= perf_md_stalls + 32'd1;
            if (fwd_event && !(&perf_fwd_events))
                perf_fwd_events <= perf_fwd_events + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_forward_scoreboard.sv
// Self-checking bench for hazard_forward_scoreboard: directed vectors,
// a cycle-indexed reference model and a per-cycle compare process.
module tb_hazard_forward_scoreboard;

    localparam int W = 5;
    localparam int L = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         id_valid, id_rs_used, id_rt_used, id_is_md;
    logic [W-1:0] id_rs, id_rt;
    logic         ex_RegWrite, ex_MemRead;
    logic [W-1:0] ex_RegisterRd, exe_Rs, exe_Rt;
    logic         mem_RegWrite, wb_RegWrite;
    logic [W-1:0] mem_RegisterRd, wb_RegisterRd;
    logic         md_start;
    logic [W-1:0] md_rd;
    logic [1:0]   ForwardA, ForwardB;
    logic         stall_if_id, bubble_id_ex, md_busy, md_wb_valid;
    logic [W-1:0] md_wb_rd;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0]  perf_lu_stalls, perf_md_stalls, perf_fwd_events;
`endif

    int vectors = 0;
    int errors  = 0;

    hazard_forward_scoreboard #(.REG_ADDR_W(W), .MD_LATENCY(L)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .id_is_md(id_is_md),
        .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead),
        .ex_RegisterRd(ex_RegisterRd),
        .exe_Rs(exe_Rs), .exe_Rt(exe_Rt),
        .mem_RegWrite(mem_RegWrite), .wb_RegWrite(wb_RegWrite),
        .mem_RegisterRd(mem_RegisterRd), .wb_RegisterRd(wb_RegisterRd),
        .md_start(md_start), .md_rd(md_rd),
        .ForwardA(ForwardA), .ForwardB(ForwardB),
        .stall_if_id(stall_if_id), .bubble_id_ex(bubble_id_ex),
        .md_busy(md_busy), .md_wb_valid(md_wb_valid),
        .md_wb_rd(md_wb_rd)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .perf_lu_stalls(perf_lu_stalls),
        .perf_md_stalls(perf_md_stalls),
        .perf_fwd_events(perf_fwd_events)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: cycle index, issue cycle of the accepted MD op
    // and its destination. Result is valid exactly L cycles after issue.
    int          cyc = 0;
    int          iss = -1;
    logic [W-1:0] prd = '0;
    logic [31:0] m_lu = 0, m_md = 0, m_fwd = 0;

    function automatic bit m_busy();
        return iss >= 0 && cyc > iss && cyc < iss + L;
    endfunction

    function automatic bit m_done();
        return iss >= 0 && cyc == iss + L;
    endfunction

    function automatic logic [1:0] m_sel(input logic [W-1:0] s);
        if (s == 0) return 2'b00;
        if (m_done() && prd == s) return 2'b11;
        if (mem_RegWrite && mem_RegisterRd == s) return 2'b10;
        if (wb_RegWrite && wb_RegisterRd == s) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit uses(input logic [W-1:0] r);
        return (id_rs_used && id_rs == r) || (id_rt_used && id_rt == r);
    endfunction

    function automatic bit m_lu_haz();
        return id_valid && ex_MemRead && ex_RegWrite
               && ex_RegisterRd != 0 && uses(ex_RegisterRd);
    endfunction

    function automatic bit m_md_haz();
        return id_valid && m_busy()
               && (id_is_md || (prd != 0 && uses(prd)));
    endfunction

    function automatic logic [31:0] sat(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            iss  = -1;
            prd  = '0;
            m_lu = 0;
            m_md = 0;
            m_fwd = 0;
        end else begin
            if (m_lu_haz()) m_lu = sat(m_lu);
            if (m_md_haz()) m_md = sat(m_md);
            if (m_sel(exe_Rs) != 0 || m_sel(exe_Rt) != 0)
                m_fwd = sat(m_fwd);
            if (md_start && !m_busy()) begin
                iss = cyc;
                prd = md_rd;
            end
        end
        cyc++;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        bit h;
        if (rst) begin
            chk("m_fwdA", 32'(ForwardA), 0);
            chk("m_fwdB", 32'(ForwardB), 0);
            chk("m_stall", 32'(stall_if_id), 0);
            chk("m_bubble", 32'(bubble_id_ex), 0);
            chk("m_busy", 32'(md_busy), 0);
            chk("m_valid", 32'(md_wb_valid), 0);
            chk("m_rd", 32'(md_wb_rd), 0);
        end else begin
            h = m_lu_haz() || m_md_haz();
            chk("m_fwdA", 32'(ForwardA), 32'(m_sel(exe_Rs)));
            chk("m_fwdB", 32'(ForwardB), 32'(m_sel(exe_Rt)));
            chk("m_stall", 32'(stall_if_id), 32'(h));
            chk("m_bubble", 32'(bubble_id_ex), 32'(h));
            chk("m_busy", 32'(md_busy), 32'(m_busy()));
            chk("m_valid", 32'(md_wb_valid), 32'(m_done()));
            if (m_busy() || m_done())
                chk("m_rd", 32'(md_wb_rd), 32'(prd));
        end
`ifdef HAZARD_PERF_CNT_EN
        chk("m_plu", perf_lu_stalls, rst ? 0 : m_lu);
        chk("m_pmd", perf_md_stalls, rst ? 0 : m_md);
        chk("m_pfwd", perf_fwd_events, rst ? 0 : m_fwd);
`endif
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic clear();
        id_valid = 0; id_rs = 0; id_rt = 0;
        id_rs_used = 0; id_rt_used = 0; id_is_md = 0;
        ex_RegWrite = 0; ex_MemRead = 0; ex_RegisterRd = 0;
        exe_Rs = 0; exe_Rt = 0;
        mem_RegWrite = 0; wb_RegWrite = 0;
        mem_RegisterRd = 0; wb_RegisterRd = 0;
        md_start = 0; md_rd = 0;
    endtask

    initial begin
        clear();
        rst = 1;
        // forwarding inputs active during reset must not leak out
        mem_RegWrite = 1; mem_RegisterRd = 3; exe_Rs = 3;
        step(); step();
        at_neg();
        chk("rst_fwdA", 32'(ForwardA), 0);
        chk("rst_busy", 32'(md_busy), 0);
        chk("rst_valid", 32'(md_wb_valid), 0);
        chk("rst_rd", 32'(md_wb_rd), 0);

        step();
        rst = 0;
        wb_RegWrite = 1; wb_RegisterRd = 3; exe_Rt = 0;
        at_neg();
        chk("prio_memA", 32'(ForwardA), 32'h2);
        chk("prio_B0", 32'(ForwardB), 32'h0);

        step();
        mem_RegWrite = 0;
        at_neg();
        chk("prio_wbA", 32'(ForwardA), 32'h1);

        step();
        wb_RegisterRd = 0; exe_Rs = 0;
        at_neg();
        chk("zero_src", 32'(ForwardA), 32'h0);

        // load-use
        step();
        clear();
        ex_MemRead = 1; ex_RegWrite = 1; ex_RegisterRd = 8;
        id_valid = 1; id_rt = 8; id_rt_used = 1;
        at_neg();
        chk("lu_stall", 32'(stall_if_id), 1);
        chk("lu_bubble", 32'(bubble_id_ex), 1);

        step();
        ex_MemRead = 0;
        at_neg();
        chk("lu_1cyc", 32'(stall_if_id), 0);

        step();
        ex_MemRead = 1; id_rt_used = 0;
        at_neg();
        chk("lu_unused", 32'(stall_if_id), 0);

        step();
        id_rt_used = 1;
        at_neg();
        chk("lu_second", 32'(stall_if_id), 1);

        // MD issue at T with rd=5
        step();
        clear();
        md_start = 1; md_rd = 5;
        at_neg();
        chk("md_T_busy", 32'(md_busy), 0);

        step();                  // T+1
        md_start = 0;
        id_valid = 1; id_rs = 5; id_rs_used = 1;
        at_neg();
        chk("md_T1_busy", 32'(md_busy), 1);
        chk("md_T1_stall", 32'(stall_if_id), 1);

        step();                  // T+2
        at_neg();
        chk("md_T2_stall", 32'(stall_if_id), 1);

        step();                  // T+3
        at_neg();
        chk("md_T3_busy", 32'(md_busy), 1);
        chk("md_T3_stall", 32'(stall_if_id), 1);

        step();                  // T+4: DONE, reissue rd=7
        exe_Rs = 5;
        md_start = 1; md_rd = 7;
        at_neg();
        chk("md_T4_valid", 32'(md_wb_valid), 1);
        chk("md_T4_rd", 32'(md_wb_rd), 5);
        chk("md_T4_fwdA", 32'(ForwardA), 32'h3);
        chk("md_T4_stall", 32'(stall_if_id), 0);
        chk("md_T4_busy", 32'(md_busy), 0);
`ifdef HAZARD_PERF_CNT_EN
        chk("perf_lu2", perf_lu_stalls, 2);
        chk("perf_md3", perf_md_stalls, 3);
`endif

        step();                  // T+5: busy again, no IDLE gap
        md_start = 0; exe_Rs = 0;
        id_rs_used = 0; id_is_md = 1;
        at_neg();
        chk("b2b_busy", 32'(md_busy), 1);
        chk("md_is_md", 32'(stall_if_id), 1);

        step(); step(); step();  // T+8
        at_neg();
        chk("b2b_valid", 32'(md_wb_valid), 1);
        chk("b2b_rd", 32'(md_wb_rd), 7);
        chk("b2b_release", 32'(stall_if_id), 0);

        step();
        clear();
        at_neg();
        chk("b2b_idle", 32'(md_wb_valid), 0);

        // md_start while busy must be ignored
        step();
        md_start = 1; md_rd = 9;
        step();
        md_rd = 10;
        step();
        md_start = 0;
        step();
        step();
        at_neg();
        chk("ign_valid", 32'(md_wb_valid), 1);
        chk("ign_rd", 32'(md_wb_rd), 9);

        // reset mid-MD
        step();
        clear();
        md_start = 1; md_rd = 6;
        id_valid = 1; id_rs = 6; id_rs_used = 1;
        step();
        md_start = 0;
        step();
        at_neg();
        chk("rmid_stall", 32'(stall_if_id), 1);
        rst = 1;
        #1;
        chk("rmid_busy", 32'(md_busy), 0);
        chk("rmid_stall0", 32'(stall_if_id), 0);
        chk("rmid_valid", 32'(md_wb_valid), 0);
        step();
        rst = 0;
        for (int i = 0; i < 5; i++) begin
            at_neg();
            chk("rmid_nopulse", 32'(md_wb_valid), 0);
            step();
        end

`ifdef HAZARD_PERF_CNT_EN
        // saturation of a preloaded counter
        clear();
        force dut.perf_lu_stalls = 32'hFFFF_FFFF;
        m_lu = 32'hFFFF_FFFF;
        #1;
        release dut.perf_lu_stalls;
        ex_MemRead = 1; ex_RegWrite = 1; ex_RegisterRd = 4;
        id_valid = 1; id_rs = 4; id_rs_used = 1;
        step();
        step();
        at_neg();
        chk("perf_sat", perf_lu_stalls, 32'hFFFF_FFFF);
`endif

        step();
        clear();
        step();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule

// File: doc/hazard_forward_scoreboard.md
Name: hazard_forward_scoreboard

Overview:
- Parametrised successor of the pipeline bypass logic.
- Produces EX-stage operand forward selects from MEM, WB and a multi-cycle mult/div (MD) unit.
- Detects load-use hazards, and tracks the one outstanding MD destination register with a countdown scoreboard.
- Drives IF/ID hold and ID/EX bubble for the 5-stage CPU, sitting beside the control unit between ID and EX.

Parameters:
- REG_ADDR_W, 5, register-index width; index 0 is the hard-wired zero register.
- MD_LATENCY, 4, cycles from MD issue to result-valid; legal range 2..15.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  asynchronous reset, active-high.
- id_valid  input  1  ID holds a real instruction.
- id_rs / id_rt  input  REG_ADDR_W  ID source indices.
- id_rs_used / id_rt_used  input  1  ID instruction actually reads that source.
- id_is_md  input  1  ID instruction is an MD op.
- ex_RegWrite, ex_MemRead  input  1  EX instruction writes a register / is a load.
- ex_RegisterRd  input  REG_ADDR_W  EX destination.
- exe_Rs / exe_Rt  input  REG_ADDR_W  EX source indices.
- mem_RegWrite, wb_RegWrite  input  1  write enables.
- mem_RegisterRd, wb_RegisterRd  input  REG_ADDR_W  destinations.
- md_start  input  1  EX issues an MD op this cycle.
- md_rd  input  REG_ADDR_W  MD destination, sampled with md_start.
- ForwardA / ForwardB  output  2  00 regfile, 01 WB, 10 MEM, 11 MD result.
- stall_if_id  output  1  hold PC and IF/ID.
- bubble_id_ex  output  1  load NOP into ID/EX.
- md_busy  output  1  scoreboard occupied.
- md_wb_valid  output  1  MD result writes md_wb_rd this cycle.
- md_wb_rd  output  REG_ADDR_W  registered MD destination.

Behaviour:
- Reset: state IDLE; counter 0; pending register 0. All registered outputs are 0 (md_busy, md_wb_valid, md_wb_rd).
- Combinational outputs evaluate to 0 during reset: ForwardA, ForwardB, stall_if_id, bubble_id_ex.
- Reset mid-operation abandons the pending MD op with no md_wb_valid pulse.
- FSM states:
  - IDLE: md_start -> BUSY; counter loads MD_LATENCY-1; md_rd is captured.
  - BUSY: counter decrements each cycle. On the cycle it reads 1, the next state is DONE.
  - DONE: lasts one cycle with md_wb_valid=1. md_start -> BUSY (reload, back-to-back allowed); otherwise -> IDLE.
- md_busy = (state==BUSY).
- md_start while BUSY is ignored. The scoreboard is unchanged. Upstream must prevent this through the stall below.
- Latency: md_start at cycle T gives md_wb_valid at cycle T+MD_LATENCY.
- Forwarding priority per operand, evaluated independently for A (exe_Rs) and B (exe_Rt):
  1. 11 when md_wb_valid and md_wb_rd != 0 and md_wb_rd == source.
  2. 10 when mem_RegWrite and mem_RegisterRd != 0 and it matches.
  3. 01 when wb_RegWrite and wb_RegisterRd != 0 and it matches.
  4. 00 otherwise.
- Source 0 always selects 00.
- Load-use hazard when all of these hold: id_valid, ex_MemRead, ex_RegWrite, ex_RegisterRd != 0, and ex_RegisterRd equals a used ID source.
- MD hazard when id_valid and md_busy, and either:
  - id_is_md is set, or
  - a used ID source equals md_wb_rd (md_wb_rd != 0).
- stall_if_id = bubble_id_ex = load-use hazard OR MD hazard. These are combinational, same cycle.
- A load-use hazard lasts one cycle, because the bubble clears ex_MemRead.
- An MD hazard persists until DONE; release happens in the DONE cycle, and the dependent instruction then receives 11 in EX next cycle only if still DONE. Otherwise it reads the written regfile.
- Unused sources (used=0) never stall.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- When defined, adds three 32-bit outputs: perf_lu_stalls, perf_md_stalls, perf_fwd_events.
  - perf_lu_stalls and perf_md_stalls count cycles with each hazard. A cycle with both hazards increments both.
  - perf_fwd_events counts cycles where ForwardA or ForwardB is nonzero.
  - Counters saturate at 0xFFFFFFFF and reset to 0 on rst.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Forwarding priority: mem_RegWrite=1, mem_RegisterRd=3, wb_RegWrite=1, wb_RegisterRd=3, exe_Rs=3, exe_Rt=0 -> ForwardA=10, ForwardB=00. Then mem_RegWrite=0 -> ForwardA=01.
- Load-use: ex_MemRead=1, ex_RegWrite=1, ex_RegisterRd=8, id_valid=1, id_rt=8, id_rt_used=1 -> stall_if_id=bubble_id_ex=1 for exactly 1 cycle. Repeat with id_rt_used=0 -> no stall.
- MD latency, default MD_LATENCY=4: md_start=1, md_rd=5 at T -> md_busy=1 at T+1..T+3; md_wb_valid=1 and md_wb_rd=5 at T+4 only. exe_Rs=5 at T+4 -> ForwardA=11.
- MD stall: at T+1, id_valid=1, id_rs=5, id_rs_used=1 -> stall through T+3, released at T+4. A second id_is_md during BUSY stalls identically. md_start in the DONE cycle reloads with no IDLE gap.
- Reset: assert rst at T+2 mid-MD -> md_busy, md_wb_valid and stall drop immediately (asynchronously). No md_wb_valid pulse follows after rst deasserts.
- Perf counters (macro defined): two load-use stalls plus three MD-stall cycles -> perf_lu_stalls=2, perf_md_stalls=3. Counter preloaded to 0xFFFFFFFF via force stays saturated.
